// File: rtl/bt_pkg.sv
// Shared definitions for the balanced-ternary sequential ALU.
// Trit codes, op codes, FSM states and trit helpers.
package bt_pkg;

  localparam logic [1:0] T_NEG  = 2'b01;
  localparam logic [1:0] T_ZERO = 2'b11;
  localparam logic [1:0] T_POS  = 2'b10;
  localparam logic [1:0] T_BAD  = 2'b00;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  function automatic logic [1:0] trit_neg(
    input logic [1:0] t
  );
    return {t[0], t[1]};
  endfunction

  // Illegal code 00 reads as 0; it never reaches the adder when it matters.
  function automatic logic signed [2:0] trit_val(
    input logic [1:0] t
  );
    return (t == T_POS) ? 3'sd1 :
           (t == T_NEG) ? -3'sd1 : 3'sd0;
  endfunction

endpackage

// File: rtl/bt_full_adder.sv
// Balanced-ternary full adder: a + b + cin = 3*cout + s.
// All inputs and outputs are trit-coded.
module bt_full_adder
  import bt_pkg::*;
(
  input  logic [1:0] a,
  input  logic [1:0] b,
  input  logic [1:0] cin,
  output logic [1:0] s,
  output logic [1:0] cout
);

  logic signed [2:0] sum;

  always_comb begin
    sum  = trit_val(a) + trit_val(b) + trit_val(cin);
    s    = T_ZERO;
    cout = T_ZERO;
    case (sum)
      -3'sd3: cout = T_NEG;
      -3'sd2: begin
        s    = T_POS;
        cout = T_NEG;
      end
      -3'sd1: s = T_NEG;
      3'sd1:  s = T_POS;
      3'sd2: begin
        s    = T_NEG;
        cout = T_POS;
      end
      3'sd3:  cout = T_POS;
      default: ;
    endcase
  end

endmodule

// File: rtl/bt_seq_alu.sv
// Sequential balanced-ternary ALU: 1-cycle add/sub,
// trit-serial shift-add multiply with start/busy/done.
module bt_seq_alu
  import bt_pkg::*;
#(
  parameter int TRITS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [1:0]           op,
  input  logic [2*TRITS-1:0]   a,
  input  logic [2*TRITS-1:0]   b,
  output logic                 busy,
  output logic                 done,
  output logic                 illegal,
  output logic [4*TRITS-1:0]   result
);

  localparam int W  = 2*TRITS;
  localparam int RW = 4*TRITS;
  localparam int CW = $clog2(TRITS);

  state_t state, state_nx;

  logic [W-1:0]    a_q, b_q, a_neg, b_neg, pp;
  logic [RW-1:0]   acc, pp_w, add_x, add_y, add_s;
  logic [RW+1:0]   carry;
  logic [CW-1:0]   cnt;
  logic [1:0]      b_trit;
  logic            bad_trit, req_bad, last;

  always_comb begin
    bad_trit = 1'b0;
    for (int i = 0; i < TRITS; i++) begin
      bad_trit = bad_trit
        | (a[2*i+:2] == T_BAD)
        | (b[2*i+:2] == T_BAD);
      a_neg[2*i+:2] = trit_neg(a_q[2*i+:2]);
      b_neg[2*i+:2] = trit_neg(b[2*i+:2]);
    end
  end

  assign req_bad = bad_trit | (op == OP_RSV);
  assign last    = (cnt == CW'(TRITS-1));
  assign b_trit  = b_q[2*cnt+:2];

  always_comb begin
    pp = {TRITS{T_ZERO}};
    unique case (1'b1)
      (b_trit == T_POS): pp = a_q;
      (b_trit == T_NEG): pp = a_neg;
      default: ;
    endcase
  end

  // Shift the partial product up cnt trits, filling with zero trits.
  assign pp_w = ({{TRITS{T_ZERO}}, pp} << (2*cnt))
              | ~({RW{1'b1}} << (2*cnt));

  // One adder serves both the add/sub request and the multiply iterations.
  always_comb begin
    add_x = acc;
    add_y = pp_w;
    if (state != S_MUL) begin
      add_x = {{TRITS{T_ZERO}}, a};
      add_y = {{TRITS{T_ZERO}}, (op == OP_SUB) ? b_neg : b};
    end
  end

  assign carry[1:0] = T_ZERO;

  for (genvar g = 0; g < 2*TRITS; g++) begin : g_fa
    bt_full_adder u_fa (
      .a    (add_x[2*g+:2]),
      .b    (add_y[2*g+:2]),
      .cin  (carry[2*g+:2]),
      .s    (add_s[2*g+:2]),
      .cout (carry[2*g+2+:2])
    );
  end

  a_top_carry: assert property (
    @(posedge clk) disable iff (!rst_n)
    carry[RW+:2] == T_ZERO
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_MUL: if (last) state_nx = S_DONE;
      default: begin
        state_nx = S_IDLE;
        if (start)
          state_nx = (!req_bad && op == OP_MUL)
                   ? S_MUL : S_DONE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '1;
      b_q     <= '1;
      acc     <= '1;
      cnt     <= '0;
      result  <= '1;
      illegal <= 1'b0;
    end else if (state == S_MUL) begin
      acc <= add_s;
      cnt <= cnt + 1'b1;
      if (last) begin
        result  <= add_s;
        illegal <= 1'b0;
      end
    end else if (start) begin
      a_q <= a;
      b_q <= b;
      acc <= '1;
      cnt <= '0;
      if (req_bad) begin
        result  <= '1;
        illegal <= 1'b1;
      end else if (op != OP_MUL) begin
        result  <= add_s;
        illegal <= 1'b0;
      end
    end
  end

  assign busy = (state == S_MUL);
  assign done = (state == S_DONE);

endmodule

// File: tb/tb_bt_seq_alu.sv
// Bench for bt_seq_alu: directed TRITS=2 cases and a
// TRITS=4 random run against a decimal reference.
module tb_bt_seq_alu;
  import bt_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start2 = 1'b0;
  logic [1:0]  op2 = '0;
  logic [3:0]  a2 = '0, b2 = '0;
  logic        busy2, done2, ill2;
  logic [7:0]  res2;

  logic        start4 = 1'b0;
  logic [1:0]  op4 = '0;
  logic [7:0]  a4 = '0, b4 = '0;
  logic        busy4, done4, ill4;
  logic [15:0] res4;

  bt_seq_alu #(.TRITS(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2),
    .op(op2), .a(a2), .b(b2),
    .busy(busy2), .done(done2),
    .illegal(ill2), .result(res2)
  );

  bt_seq_alu #(.TRITS(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4),
    .op(op4), .a(a4), .b(b4),
    .busy(busy4), .done(done4),
    .illegal(ill4), .result(res4)
  );

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [7:0] res;
    logic       ill;
    int         lat;
  } exp2_t;

  typedef struct {
    int val;
    int lat;
  } exp4_t;

  exp2_t q2[$];
  exp4_t q4[$];

  function automatic logic [1:0] enc(input int t);
    return (t > 0) ? T_POS : (t < 0) ? T_NEG : T_ZERO;
  endfunction

  task automatic launch2(
    input logic [1:0] op, input logic [3:0] a,
    input logic [3:0] b, input logic [7:0] r,
    input logic ill, input int lat
  );
    exp2_t e;
    e.res = r; e.ill = ill; e.lat = lat;
    q2.push_back(e);
    start2 = 1'b1; op2 = op; a2 = a; b2 = b;
  endtask

  task automatic wait_done2(output int lat, output int nb);
    lat = -1; nb = 0;
    for (int k = 1; k <= 20 && lat < 0; k++) begin
      @(negedge clk);
      start2 = 1'b0; a2 = '0; b2 = '0;
      if (busy2 === 1'b1) nb++;
      if (done2 === 1'b1) lat = k;
    end
  endtask

  task automatic test_reset();
    #1;
    total++;
    if ({busy2, done2, ill2} !== 3'b000) begin
      bad++;
      $display("FAIL reset_flags2 got=%b exp=000", {busy2, done2, ill2});
    end
    total++;
    if (res2 !== 8'hFF) begin
      bad++;
      $display("FAIL reset_res2 got=%h exp=ff", res2);
    end
    total++;
    if ({busy4, done4, ill4, res4} !== {3'b000, 16'hFFFF}) begin
      bad++;
      $display("FAIL reset_dut4 got=%b/%h exp=000/ffff",
               {busy4, done4, ill4}, res4);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mul();
    logic [3:0] ta[2] = '{4'b0101, 4'b0111};
    logic [3:0] tb[2] = '{4'b0101, 4'b1001};
    logic [7:0] tr[2] = '{8'h96, 8'hDB};
    int lat, nb;
    exp2_t e;
    for (int i = 0; i < 2; i++) begin
      launch2(OP_MUL, ta[i], tb[i], tr[i], 1'b0, 3);
      wait_done2(lat, nb);
      e = q2.pop_front();
      total++;
      if (lat !== e.lat || nb !== 2) begin
        bad++;
        $display("FAIL mul_timing[%0d] got lat=%0d busy=%0d exp lat=%0d busy=2",
                 i, lat, nb, e.lat);
      end
      total++;
      if (res2 !== e.res || ill2 !== e.ill) begin
        bad++;
        $display("FAIL mul_res[%0d] got=%h/%b exp=%h/%b",
                 i, res2, ill2, e.res, e.ill);
      end
    end
  endtask

  task automatic test_addsub();
    logic [1:0] to[5] = '{OP_ADD, OP_ADD, OP_SUB, OP_SUB, OP_RSV};
    logic [3:0] ta[5] = '{4'b1101, 4'b1010, 4'b1010, 4'b0010, 4'b1111};
    logic [3:0] tb[5] = '{4'b0101, 4'b1010, 4'b0101, 4'b0101, 4'b1111};
    logic [7:0] tr[5] = '{8'hDA, 8'hED, 8'hED, 8'hFF, 8'hFF};
    logic       ti[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    int lat, nb;
    exp2_t e;
    for (int i = 0; i < 5; i++) begin
      launch2(to[i], ta[i], tb[i], tr[i], ti[i], 1);
      wait_done2(lat, nb);
      e = q2.pop_front();
      total++;
      if (lat !== e.lat || nb !== 0) begin
        bad++;
        $display("FAIL addsub_timing[%0d] got lat=%0d busy=%0d exp lat=1 busy=0",
                 i, lat, nb);
      end
      total++;
      if (res2 !== e.res || ill2 !== e.ill) begin
        bad++;
        $display("FAIL addsub_res[%0d] got=%h/%b exp=%h/%b",
                 i, res2, ill2, e.res, e.ill);
      end
    end
  endtask

  task automatic test_busy_ignore();
    int lat, nb, extra;
    exp2_t e;
    launch2(OP_MUL, 4'b0111, 4'b1001, 8'hDB, 1'b0, 3);
    @(negedge clk);
    total++;
    if (busy2 !== 1'b1) begin
      bad++;
      $display("FAIL busy_c1 got=%b exp=1", busy2);
    end
    start2 = 1'b1; op2 = OP_ADD; a2 = 4'b1010; b2 = 4'b1010;
    @(negedge clk);
    wait_done2(lat, nb);
    e = q2.pop_front();
    total++;
    if (lat !== 1 || res2 !== e.res) begin
      bad++;
      $display("FAIL busy_ignore got lat=%0d res=%h exp lat=1 res=%h",
               lat, res2, e.res);
    end
    extra = 0;
    repeat (4) begin
      @(negedge clk);
      if (done2 === 1'b1) extra++;
    end
    total++;
    if (extra !== 0) begin
      bad++;
      $display("FAIL busy_extra_done got=%0d exp=0", extra);
    end
  endtask

  task automatic test_back_to_back();
    int lat, nb;
    exp2_t e;
    launch2(OP_ADD, 4'b1101, 4'b0101, 8'hDA, 1'b0, 1);
    wait_done2(lat, nb);
    for (int i = 0; i < 3; i++) begin
      e = q2.pop_front();
      total++;
      if (lat !== e.lat || res2 !== e.res) begin
        bad++;
        $display("FAIL b2b[%0d] got lat=%0d res=%h exp lat=%0d res=%h",
                 i, lat, res2, e.lat, e.res);
      end
      if (i == 0) launch2(OP_ADD, 4'b1010, 4'b1010, 8'hED, 1'b0, 1);
      if (i == 1) launch2(OP_SUB, 4'b1101, 4'b1101, 8'hFF, 1'b0, 1);
      if (i < 2) wait_done2(lat, nb);
    end
    @(negedge clk);
    total++;
    if (done2 !== 1'b0) begin
      bad++;
      $display("FAIL b2b_pulse got=%b exp=0", done2);
    end
  endtask

  task automatic test_reset_mid();
    int extra;
    start2 = 1'b1; op2 = OP_ADD; a2 = 4'b1010; b2 = 4'b1010;
    @(negedge clk);
    start2 = 1'b1; op2 = OP_MUL; a2 = 4'b0101; b2 = 4'b0101;
    @(negedge clk);
    start2 = 1'b0;
    total++;
    if (busy2 !== 1'b1 || res2 !== 8'hED) begin
      bad++;
      $display("FAIL rstmid_pre got busy=%b res=%h exp busy=1 res=ed",
               busy2, res2);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({busy2, done2, ill2, res2} !== {3'b000, 8'hFF}) begin
      bad++;
      $display("FAIL rstmid_out got=%b/%h exp=000/ff",
               {busy2, done2, ill2}, res2);
    end
    @(negedge clk);
    rst_n = 1'b1;
    extra = 0;
    repeat (6) begin
      @(negedge clk);
      if (done2 === 1'b1) extra++;
    end
    total++;
    if (extra !== 0 || res2 !== 8'hFF) begin
      bad++;
      $display("FAIL rstmid_after got done=%0d res=%h exp done=0 res=ff",
               extra, res2);
    end
  endtask

  task automatic test_random4();
    int da, db, t, p, lat, v;
    logic [1:0] op;
    logic [1:0] tr;
    logic ok;
    exp4_t e;
    for (int n = 0; n < 1200; n++) begin
      da = 0; db = 0; p = 1;
      for (int i = 0; i < 4; i++) begin
        t = int'($urandom_range(2)) - 1;
        a4[2*i+:2] = enc(t);
        da += t * p;
        t = int'($urandom_range(2)) - 1;
        b4[2*i+:2] = enc(t);
        db += t * p;
        p *= 3;
      end
      op = 2'($urandom_range(2));
      e.val = (op == OP_ADD) ? da + db :
              (op == OP_SUB) ? da - db : da * db;
      e.lat = (op == OP_MUL) ? 5 : 1;
      q4.push_back(e);
      op4 = op;
      start4 = 1'b1;
      lat = -1;
      for (int k = 1; k <= 20 && lat < 0; k++) begin
        @(negedge clk);
        start4 = 1'b0; a4 = '0; b4 = '0;
        if (done4 === 1'b1) lat = k;
      end
      e = q4.pop_front();
      v = 0; p = 1; ok = 1'b1;
      for (int i = 0; i < 8; i++) begin
        tr = res4[2*i+:2];
        if (tr == T_POS) v += p;
        else if (tr == T_NEG) v -= p;
        else if (tr != T_ZERO) ok = 1'b0;
        p *= 3;
      end
      total++;
      if (lat !== e.lat) begin
        bad++;
        $display("FAIL rnd_lat[%0d] op=%0d got=%0d exp=%0d",
                 n, op, lat, e.lat);
      end
      total++;
      if (!ok || v !== e.val || ill4 !== 1'b0) begin
        bad++;
        $display("FAIL rnd_val[%0d] op=%0d a=%0d b=%0d got=%0d (%h ill=%b) exp=%0d",
                 n, op, da, db, v, res4, ill4, e.val);
      end
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    test_reset();
    test_mul();
    test_addsub();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
    test_random4();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bt_seq_alu.md
Name: bt_seq_alu

Overview:
- Parametrised, clocked successor to the 2-trit balanced-ternary calculator.
- Operates on TRITS-trit binary-coded balanced-ternary operands. Supports add, subtract and multiply.
- Add and subtract complete in a single cycle. Multiply is a trit-serial shift-add sequencer with a start/busy/done handshake and illegal-code detection.
- Sits behind the tapeout IO wrapper or any host that loads operands and pulses start.

Parameters:
- TRITS, 4, trits per operand (>=2). The result carries 2*TRITS trits.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request pulse. Sampled only in IDLE or DONE.
- op  in  2  00 add, 01 subtract (a-b), 10 multiply, 11 reserved.
- a  in  2*TRITS  operand A, trit i at bits [2i+1:2i].
- b  in  2*TRITS  operand B, same packing.
- busy  out  1  multiply iteration in progress.
- done  out  1  single-cycle pulse; result valid.
- illegal  out  1  last accepted request had a 00 trit or op=11.
- result  out  4*TRITS  2*TRITS-trit balanced-ternary result.

Behaviour:
- Trit encoding: 01 = -1, 11 = 0, 10 = +1, 00 = illegal. Negation is a bit swap within each trit (01<->10, 11 unchanged).
- Reset (async, any state):
  - state goes to IDLE.
  - busy=0, done=0, illegal=0.
  - result = all ones (every trit 0).
- States: IDLE, MUL, DONE.
- start in IDLE or DONE captures a, b and op at that edge (cycle 0):
  - Any 00 trit in a or b, or op=11: goto DONE. illegal=1, result = all ones, done=1 in cycle 1.
  - Add / subtract: goto DONE. result = a + b, or a + neg(b), in the low TRITS+1 trits; upper trits 11. illegal=0, done=1 in cycle 1.
  - Multiply: goto MUL. acc cleared to 0, iteration counter = 0, busy=1 from cycle 1.
- MUL state, iteration i = 0..TRITS-1, one per cycle (cycles 1..TRITS):
  - Partial product is a, neg(a) or 0, selected by b trit i.
  - The partial product, shifted up i trits, is added into the 2*TRITS-trit acc.
  - After the last iteration: goto DONE, result = acc, illegal=0.
  - done=1 and busy=0 in cycle TRITS+1.
- DONE lasts one cycle, then returns to IDLE unless start is asserted.
  - start in DONE is accepted (back-to-back). done stays a one-cycle pulse per request.
- start while busy is ignored. Operands may change freely after cycle 0.
- result and illegal hold until the next completion.
- No overflow is possible: |a*b| and |a±b| fit in 2*TRITS trits.
- Adder: ripple of trit full adders. Trit inputs a, b and carry-in, all in {-1,0,1}, give a sum trit and a carry trit. The carry out of the top acc trit is discarded and is provably 0.
- Reset asserted mid-multiply: the operation is aborted with no done pulse, and outputs go to their reset values.

Decomposition:
- Shared package bt_pkg:
  - trit constants T_NEG=2'b01, T_ZERO=2'b11, T_POS=2'b10, T_BAD=2'b00.
  - op constants OP_ADD, OP_SUB, OP_MUL, OP_RSV.
  - state encoding.
  - function trit_neg.
- Sub-module bt_full_adder: combinational trit full adder (a, b, cin -> s, cout). The accumulator/adder path instantiates 2*TRITS of them via generate.
- The illegal-code check is an inline reduction. No separate module.

Test Plan (TRITS=2 instance unless noted):
- Multiply: a=0101 (-4), b=0101 (-4), op=10 -> busy 2 cycles, done in cycle 3, result=8'h96 (+16).
- Multiply: a=0111 (-3), b=1001 (+2), op=10 -> done cycle 3, result=8'hDB (-6).
- Add: a=1101 (-1), b=0101 (-4) -> done cycle 1, result=8'hDA (-5). Repeat with a=b=1010 (+4) -> result=8'hED (+8).
- Subtract: a=1010 (+4), b=0101 (-4), op=01 -> result=8'hED, illegal=0. Then a=0010 -> illegal=1, result=8'hFF, done cycle 1.
- Handshake: start again during busy is ignored. start held in the DONE cycle launches a new add with done on the next cycle. Reset asserted in MUL cycle 1 gives busy=0, done never pulses, result=8'hFF.
- TRITS=4, random legal operands (>=1000) -> result matches a decimal reference model. done latency is exactly 1 for add/sub and 5 for multiply.
